// File: rtl/sum_cla_pipe.sv
// sum_cla_pipe: pipelined carry-lookahead adder/subtractor, one BLOCK-bit CLA per stage
// Define SUM_CLA_PIPE_SAT_EN to add the sat input and signed saturation of the result.
module sum_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
`ifdef SUM_CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;

    // Two-level lookahead: each carry is an OR of generate terms gated by propagate prefixes.
    function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p, input logic ci);
        logic [BLOCK:0] c;
        logic pp;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            pp = p[i];
            c[i+1] = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        return c;
    endfunction

    logic [NBLK-1:0]  vld;
    logic [WIDTH-1:0] ra [NBLK];
    logic [WIDTH-1:0] rb [NBLK];
    logic [WIDTH-1:0] rs [NBLK];
    logic             rc [NBLK];
    logic             rov;
    logic [WIDTH-1:0] xa [NBLK];
    logic [WIDTH-1:0] xb [NBLK];
    logic [WIDTH-1:0] xs [NBLK];
    logic [WIDTH-1:0] ns [NBLK];
    logic             xc [NBLK];
    logic             nc [NBLK];
    logic             cm;
    logic             ov;
    logic [WIDTH-1:0] s_last;
    logic             en;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en && !reset;
    assign out_valid = vld[NBLK-1];
    assign s         = rs[NBLK-1];
    assign c_out     = rc[NBLK-1];
    assign ovf       = rov;
    assign ov        = cm ^ nc[NBLK-1];

    // Operands and partial sums ride along with each stage; stage k only fills its own block.
    always_comb begin
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        xa[0] = a;
        xb[0] = sub ? ~b : b;
        xc[0] = sub | c_in;
        xs[0] = '0;
        for (int k = 1; k < NBLK; k++) begin
            xa[k] = ra[k-1];
            xb[k] = rb[k-1];
            xc[k] = rc[k-1];
            xs[k] = rs[k-1];
        end
        cm = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            g = xa[k][k*BLOCK +: BLOCK] & xb[k][k*BLOCK +: BLOCK];
            p = xa[k][k*BLOCK +: BLOCK] ^ xb[k][k*BLOCK +: BLOCK];
            c = cla(g, p, xc[k]);
            ns[k] = xs[k];
            ns[k][k*BLOCK +: BLOCK] = p ^ c[BLOCK-1:0];
            nc[k] = c[BLOCK];
            if (k == NBLK - 1)
                cm = c[BLOCK-1];
        end
    end

`ifdef SUM_CLA_PIPE_SAT_EN
    logic rsat [NBLK];
    logic xsat [NBLK];

    always_comb begin
        xsat[0] = sat;
        for (int k = 1; k < NBLK; k++)
            xsat[k] = rsat[k-1];
    end

    // Wrapped MSB of 1 on overflow means the true result was too positive.
    assign s_last = (xsat[NBLK-1] && ov) ? {~ns[NBLK-1][WIDTH-1], {(WIDTH-1){ns[NBLK-1][WIDTH-1]}}} : ns[NBLK-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NBLK; k++)
                rsat[k] <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NBLK; k++)
                rsat[k] <= xsat[k];
        end
    end
`else
    assign s_last = ns[NBLK-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            rov <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
            end
        end else if (en) begin
            vld[0] <= in_valid;
            for (int k = 1; k < NBLK; k++)
                vld[k] <= vld[k-1];
            rov <= ov;
            for (int k = 0; k < NBLK; k++) begin
                ra[k] <= xa[k];
                rb[k] <= xb[k];
                rs[k] <= (k == NBLK - 1) ? s_last : ns[k];
                rc[k] <= nc[k];
            end
        end
    end
endmodule

// File: tb/tb_sum_cla_pipe.sv
// tb_sum_cla_pipe: directed and randomized checks of sum_cla_pipe against an arithmetic model
module tb_sum_cla_pipe;
    localparam int W = 16;
`ifdef SUM_CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
    int           checks = 0;
    int           errors = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    sum_cla_pipe #(.WIDTH(W), .BLOCK(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c_in(c_in),
        .sub(sub),
`ifdef SUM_CLA_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s(s),
        .c_out(c_out),
        .ovf(ovf)
    );

    // Reference: true integer result decides overflow and carry; result packed as {s, c_out, ovf}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb, input logic st);
        int sx, sy, t;
        logic [W-1:0] r;
        logic c, o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        t = sb ? sx - sy : sx + sy + int'(ci);
        o = (t > 32767) || (t < -32768);
        c = sb ? (x >= y) : (int'(x) + int'(y) + int'(ci) > 65535);
        r = sb ? x - y : x + y + W'(ci);
        if (SAT && st && o)
            r = (t > 0) ? 16'h7FFF : 16'h8000;
        return {r, c, o};
    endfunction

    always @(posedge clk) begin
        if (reset)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(model(a, b, c_in, sub, sat));
    end

    task automatic test_reset();
        logic seen;
        reset = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, s, c_out, ovf} !== '0) begin errors++; $display("FAIL reset_outputs got v=%b s=%h c=%b o=%b want all 0", out_valid, s, c_out, ovf); end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_ignored_input got out_valid=1 want 0"); end
    endtask

    task automatic test_latency();
        int t;
        logic found;
        @(negedge clk);
        a = 16'h0000; b = 16'h0000; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        t = 0; found = 1'b0;
        while (!found && t < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            t++;
            #1;
            if (out_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (t !== 4 || !found) begin errors++; $display("FAIL latency got %0d want 4", t); end
        checks++;
        if ({s, c_out, ovf} !== {16'h0001, 1'b0, 1'b0}) begin errors++; $display("FAIL latency_value got %h/%b/%b want 0001/0/0", s, c_out, ovf); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_directed();
        logic [W-1:0] va [8] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h0005, 16'h0005, 16'h8000, 16'h8000};
        logic [W-1:0] vb [8] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0005, 16'h0005, 16'h0005, 16'h8000, 16'h0001};
        logic         vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W+1:0] ve [8] = '{{16'h0000, 2'b10}, {16'hFFFF, 2'b10}, {16'h8000, 2'b01}, {16'hFFFE, 2'b00},
                                 {16'h0000, 2'b10}, {16'h0000, 2'b10}, {16'h0000, 2'b11}, {16'h7FFF, 2'b11}};
        int sent, got;
        sent = 0; got = 0;
        for (int t = 0; t < 40 && got < 8; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; c_in = vc[sent]; sub = vs[sent]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if ({s, c_out, ovf} !== ve[got]) begin errors++; $display("FAIL directed_%0d got %h/%b/%b want %h/%b/%b", got, s, c_out, ovf, ve[got][W+1:2], ve[got][1], ve[got][0]); end
                got++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; sub = 1'b0;
        checks++;
        if (got !== 8) begin errors++; $display("FAIL directed_count got %0d want 8", got); end
    endtask

    task automatic test_back_to_back();
        int sent, got;
        logic [W-1:0] held_s;
        logic [W+1:0] e;
        sent = 0; got = 0; held_s = '0;
        for (int t = 0; t < 60 && got < 8; t++) begin
            @(negedge clk);
            out_ready = !(t >= 6 && t <= 8);
            c_in = 1'b0; sub = 1'b0;
            if (sent < 8) begin
                a = W'(sent + 1); b = W'(16'h1111 * (sent + 1)); in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (t >= 6 && t <= 8) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", t, in_ready); end
            end
            if (t == 6) held_s = s;
            if (t == 7 || t == 8) begin
                checks++;
                if (s !== held_s || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold cycle %0d got %h/%b want %h/1", t, s, out_valid, held_s); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_spurious got %h want none", s); end
                else begin
                    e = exp_q.pop_front();
                    if ({s, c_out, ovf} !== e) begin errors++; $display("FAIL b2b_%0d got %h/%b/%b want %h/%b/%b", got, s, c_out, ovf, e[W+1:2], e[1], e[0]); end
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 8 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_count got %0d left %0d want 8 left 0", got, exp_q.size()); end
    endtask

    task automatic test_random();
        int sent, got;
        logic prev_stall;
        logic [W-1:0] prev_s;
        logic [W+1:0] e;
        sent = 0; got = 0; prev_stall = 1'b0; prev_s = '0;
        for (int t = 0; t < 400 && (t < 300 || exp_q.size() > 0 || out_valid); t++) begin
            @(negedge clk);
            out_ready = (t >= 300) || ($urandom_range(9) < 7);
            in_valid = (t < 300) && ($urandom_range(3) != 0);
            a = W'($urandom); b = W'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
            #1;
            if (prev_stall) begin
                checks++;
                if (s !== prev_s || out_valid !== 1'b1) begin errors++; $display("FAIL rand_hold got %h/%b want %h/1", s, out_valid, prev_s); end
            end
            prev_stall = out_valid && !out_ready;
            prev_s = s;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rand_spurious got %h want none", s); end
                else begin
                    e = exp_q.pop_front();
                    if ({s, c_out, ovf} !== e) begin errors++; $display("FAIL rand_%0d got %h/%b/%b want %h/%b/%b", got, s, c_out, ovf, e[W+1:2], e[1], e[0]); end
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1; sat = 1'b0; sub = 1'b0; c_in = 1'b0;
        checks++;
        if (got !== sent || exp_q.size() !== 0) begin errors++; $display("FAIL rand_count got %0d want %0d", got, sent); end
    endtask

    task automatic test_mid_reset();
        logic seen, found;
        out_ready = 1'b1; c_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = W'(16'h0100 + i); b = 16'h0002; in_valid = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || s !== '0) begin errors++; $display("FAIL midreset_flush got %b/%h want 0/0000", out_valid, s); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stale got out_valid=1 want 0"); end
        @(negedge clk);
        a = 16'h0101; b = 16'h1010; in_valid = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) found = 1'b1;
        end
        checks++;
        if (!found || {s, c_out, ovf} !== {16'h1111, 1'b0, 1'b0}) begin errors++; $display("FAIL midreset_new got %b %h/%b/%b want 1 1111/0/0", found, s, c_out, ovf); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

`ifdef SUM_CLA_PIPE_SAT_EN
    task automatic test_sat();
        logic [W-1:0] va [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
        logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h0001};
        logic         vs [3] = '{1'b0, 1'b1, 1'b0};
        logic         vt [3] = '{1'b1, 1'b1, 1'b0};
        logic [W+1:0] ve [3] = '{{16'h7FFF, 2'b01}, {16'h8000, 2'b11}, {16'h8000, 2'b01}};
        int sent, got;
        sent = 0; got = 0; out_ready = 1'b1; c_in = 1'b0;
        for (int t = 0; t < 30 && got < 3; t++) begin
            @(negedge clk);
            if (sent < 3) begin
                a = va[sent]; b = vb[sent]; sub = vs[sent]; sat = vt[sent]; in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if ({s, c_out, ovf} !== ve[got]) begin errors++; $display("FAIL sat_%0d got %h/%b/%b want %h/%b/%b", got, s, c_out, ovf, ve[got][W+1:2], ve[got][1], ve[got][0]); end
                got++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; sat = 1'b0; sub = 1'b0;
        checks++;
        if (got !== 3) begin errors++; $display("FAIL sat_count got %0d want 3", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef SUM_CLA_PIPE_SAT_EN
        test_sat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_cla_pipe.md
Name: sum_cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor of the fixed 4-bit combinational CLA adder. The operand is split into BLOCK-bit CLA blocks, with one block evaluated per pipeline stage and the carry registered between stages. It uses a valid/ready handshake on both sides and sits in the datapath as a throughput-1, fixed-latency arithmetic unit. Flags: carry out and signed overflow.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of BLOCK and >= BLOCK.
BLOCK, 4, width of each CLA block (generate/propagate lookahead inside the block).
NBLK (localparam), WIDTH/BLOCK, number of pipeline stages, which equals the latency.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set present
in_ready  output  1  unit can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry in; ignored when sub=1
sub  input  1  0: A+B+c_in; 1: A-B (A + ~B + 1)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
s  output  WIDTH  sum/difference
c_out  output  1  carry out of the MSB; for sub, 1 means no borrow
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Datapath:
  - Stage i (0..NBLK-1) computes bits [i*BLOCK +: BLOCK] using a BLOCK-bit CLA, with the carry-in coming from stage i-1's register.
  - Stage 0 carry-in is c_in, or 1 when sub=1. b is inverted in stage 0 when sub=1.
  - Unprocessed upper operand bits and already-computed lower sum bits travel down the pipeline (skew registers).
- Each stage has a valid bit. Global enable: en = !out_valid || out_ready. On a stall the whole pipeline freezes; bubbles are not collapsed.
- Input side:
  - in_ready = en && !reset (combinational).
  - A transfer occurs on an edge where in_valid && in_ready. Stage-0 valid loads in_valid whenever en=1.
- Output side:
  - s, c_out, ovf and out_valid come straight from the last stage's registers; there is no combinational path from a/b to s.
  - A result is consumed on an edge where out_valid && out_ready.
- Latency and throughput:
  - An operand set accepted at the edge ending cycle c appears with out_valid=1 in cycle c+NBLK, provided there is no stall.
  - Throughput is one result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, s, c_out, ovf and out_valid hold stable, and in_ready=0.
- Ordering: results leave in acceptance order. None may be lost or duplicated.
- Wrap-around: the sum is modulo 2^WIDTH. The carry propagates across all NBLK stages, e.g. FFFF+0001.
- NBLK=1 (WIDTH==BLOCK): single-register stage with latency 1. Functionally this is the registered form of the 4-bit CLA.
- Reset:
  - All valid bits and data/flag registers clear to 0, so s=0, c_out=0, ovf=0, out_valid=0.
  - in_ready=0 during the reset cycle and 1 in the first cycle after.
  - Reset mid-operation flushes all in-flight results; no stale out_valid may appear after reset.
  - in_valid during reset is ignored.
- Simultaneous in and out transfer in the same cycle with en=1: the pipeline advances normally.

Optional Feature:
Macro SUM_CLA_PIPE_SAT_EN. When defined:
- Adds port sat (input, 1), sampled with the operands and carried down the pipeline.
- With sat=1 and signed overflow, s clamps to 0111…1 if the overflowed result's MSB is 1 (positive overflow), or to 1000…0 otherwise. ovf is still reported as 1 and c_out is unchanged.
- Clamp logic lives in the last stage only, so latency is unchanged.

When not defined, the sat port and the clamp logic are absent.

Test Plan:
(WIDTH=16, BLOCK=4, NBLK=4, out_ready=1 unless stated.)
1. a=0000 b=0000 c_in=1 sub=0 -> s=0001 c_out=0 ovf=0, with out_valid exactly 4 cycles after acceptance.
2. a=FFFF b=0001 c_in=0 -> s=0000 c_out=1 ovf=0 (carry through all 4 stages). Then a=FFFF b=FFFF c_in=1 -> s=FFFF c_out=1 ovf=0.
3. a=7FFF b=0001 -> s=8000 c_out=0 ovf=1. Then sub=1 with a=0003 b=0005 -> s=FFFE c_out=0 ovf=0. Then sub=1 with a=0005 b=0005 -> s=0000 c_out=1.
4. 8 back-to-back operand sets (a=i, b=0x1111*i), with out_ready=0 for cycles 6-8:
   - s/out_valid hold during the stall and in_ready=0 in those cycles.
   - All 8 results appear in order, with no loss or duplication.
5. Assert reset with 3 results in flight -> out_valid=0 and s=0 from the next cycle, and no stale results afterwards. A new a=0101 b=1010 accepted after reset -> s=1111 c_out=0.
6. (SUM_CLA_PIPE_SAT_EN) sat=1:
   - a=7FFF b=0001 -> s=7FFF ovf=1.
   - sub=1, a=8000 b=0001 -> s=8000 ovf=1.
   - sat=0 with the same a=7FFF b=0001 -> s=8000.
